// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I ALU-class instructions into a registered, ready/valid issue bundle
module alu_issue_stage #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [width-1:0] rs1_data,
  input  logic [width-1:0] rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] in1,
  output logic [width-1:0] rs2_out,
  output logic [3:0]       ALUOp_control,
  output logic [2:0]       funct3,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic [width-1:0] issue_count
);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001, OP_SRL = 4'b1010, OP_SRA = 4'b1011;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  logic             out_valid_q, out_valid_d, illegal_q, illegal_d;
  logic [width-1:0] in1_q, rs2_q, cnt_q, cnt_d;
  logic [3:0]       op_q;
  logic [2:0]       f3_q;
  logic [6:0]       opc_q;
  logic [4:0]       rd_q;
  logic             dec_legal, accept, handoff, load;
  logic [3:0]       dec_op;
  logic [width-1:0] dec_b, imm_i, imm_s;
  logic [4:0]       dec_rd;
  logic [6:0]       opc, f7;
  logic [2:0]       f3;

  // funct3 to ALU code; alt selects SUB for 000 and SRA for 101
  function automatic logic [3:0] alu_map(input logic [2:0] f, input logic alt);
    case (f)
      3'b000:  alu_map = alt ? OP_SUB : OP_ADD;
      3'b001:  alu_map = OP_SLL;
      3'b010:  alu_map = OP_SLT;
      3'b011:  alu_map = OP_SLTU;
      3'b100:  alu_map = OP_XOR;
      3'b101:  alu_map = alt ? OP_SRA : OP_SRL;
      3'b110:  alu_map = OP_OR;
      default: alu_map = OP_AND;
    endcase
  endfunction

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign imm_i    = {{(width-12){instr[31]}}, instr[31:20]};
  assign imm_s    = {{(width-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign in_ready = !out_valid_q || out_ready;
  assign handoff  = out_valid_q && out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign load     = accept && dec_legal;

  // decode instruction class into legality, ALU code, operand 2 and destination
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_b     = rs2_data;
    dec_rd    = instr[11:7];
    case (opc)
      7'b0110011: begin
        dec_legal = f7 == 7'b0 || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
        dec_op    = alu_map(f3, f7[5]);
      end
      7'b0010011: begin
        dec_legal = f3 == 3'b001 ? f7 == 7'b0 : f3 == 3'b101 ? (f7 == 7'b0 || f7 == F7_ALT) : 1'b1;
        dec_op    = alu_map(f3, f3 == 3'b101 && f7[5]);
        dec_b     = imm_i;
      end
      7'b0000011: begin
        dec_legal = 1'b1;
        dec_b     = imm_i;
      end
      7'b0100011: begin
        dec_legal = 1'b1;
        dec_b     = imm_s;
        dec_rd    = 5'd0;
      end
      7'b1100011: begin
        dec_legal = f3 != 3'b010 && f3 != 3'b011;
        dec_op    = OP_SUB;
        dec_rd    = 5'd0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // flush wins over reload and handoff; a handoff still counts even under flush
  always_comb begin
    out_valid_d = flush ? 1'b0 : load ? 1'b1 : handoff ? 1'b0 : out_valid_q;
    illegal_d   = accept && !dec_legal;
    cnt_d       = handoff ? cnt_q + width'(1) : cnt_q;
  end

  // output register: bundle loads only on a legal accept, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
      in1_q       <= '0;
      rs2_q       <= '0;
      op_q        <= '0;
      f3_q        <= '0;
      opc_q       <= '0;
      rd_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
      if (load) begin
        in1_q <= rs1_data;
        rs2_q <= dec_b;
        op_q  <= dec_op;
        f3_q  <= f3;
        opc_q <= opc;
        rd_q  <= dec_rd;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign illegal       = illegal_q;
  assign issue_count   = cnt_q;
  assign in1           = in1_q;
  assign rs2_out       = rs2_q;
  assign ALUOp_control = op_q;
  assign funct3        = f3_q;
  assign opcode        = opc_q;
  assign rd            = rd_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for the ALU issue stage
module tb_alu_issue_stage;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] instr = 0, rs1_data = 0, rs2_data = 0;
  logic        in_ready, out_valid, illegal;
  logic [31:0] in1, rs2_out, issue_count;
  logic [3:0]  ALUOp_control;
  logic [2:0]  funct3;
  logic [6:0]  opcode;
  logic [4:0]  rd;

  exp_t q[$];
  exp_t e, held;
  bit   hold = 0;
  int   checks = 0, errors = 0, model_cnt = 0, exp_ill = 0, got_ill = 0, vrun = 0, c0 = 0;

  alu_issue_stage #(.width(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid),
    .out_ready(out_ready), .in1(in1), .rs2_out(rs2_out), .ALUOp_control(ALUOp_control),
    .funct3(funct3), .opcode(opcode), .rd(rd), .illegal(illegal), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // called just after a rising edge; returns just after the edge that accepted it, in_valid left high
  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input bit ok,
                      input logic [3:0] op, input logic [31:0] eb, input logic [4:0] erd);
    in_valid = 1; instr = ins; rs1_data = a; rs2_data = b;
    @(negedge clk);
    for (int n = 0; !in_ready && n < 100; n++) @(negedge clk);
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else if (ok) q.push_back('{a, eb, op, ins[14:12], ins[6:0], erd});
    else exp_ill++;
    cyc(1);
  endtask

  // monitor: pop the scoreboard on each handoff, verify stability while stalled
  always @(negedge clk) begin
    if (illegal) got_ill++;
    vrun = out_valid ? vrun + 1 : 0;
    if (hold && out_valid) begin
      chk("hold_in1", in1, held.a);
      chk("hold_b", rs2_out, held.b);
      chk("hold_op", ALUOp_control, held.op);
      chk("hold_rd", rd, held.rd);
    end
    hold = out_valid && !out_ready;
    held = '{in1, rs2_out, ALUOp_control, funct3, opcode, rd};
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_issue_qsize", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("in1", in1, e.a);
        chk("rs2_out", rs2_out, e.b);
        chk("aluop", ALUOp_control, e.op);
        chk("funct3", funct3, e.f3);
        chk("opcode", opcode, e.opc);
        chk("rd", rd, e.rd);
      end
      model_cnt++;
    end
  end

  initial begin
    #2 rst_n = 0;
    #10;
    chk("rst_valid", out_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_cnt", issue_count, 0);
    chk("rst_in1", in1, 0);
    chk("rst_b", rs2_out, 0);
    chk("rst_op", ALUOp_control, 0);
    chk("rst_rd", rd, 0);
    @(negedge clk) rst_n = 1;
    cyc(1);
    send(32'h002081B3, 5, 7, 1, 4'b0010, 7, 3);
    in_valid = 0;
    chk("add_valid", out_valid, 1);
    cyc(3);
    chk("add_cnt", issue_count, 1);
    send(32'hFFF00093, 0, 0, 1, 4'b0010, 32'hFFFFFFFF, 1);
    send(32'h4040D113, 32'h80000000, 0, 1, 4'b1011, 32'h00000404, 2);
    in_valid = 0;
    cyc(3);
    chk("imm_cnt", issue_count, model_cnt);
    out_ready = 0;
    send(32'h0020C063, 9, 3, 1, 4'b0110, 3, 0);
    in_valid = 0;
    repeat (3) begin
      chk("blt_ready", in_ready, 0);
      chk("blt_valid", out_valid, 1);
      cyc(1);
    end
    c0 = model_cnt;
    out_ready = 1;
    cyc(3);
    chk("blt_single", model_cnt - c0, 1);
    chk("blt_cnt", issue_count, model_cnt);
    c0 = model_cnt;
    send(32'h40208233, 20, 7, 1, 4'b0110, 7, 4);
    send(32'h0020C2B3, 6, 3, 1, 4'b0011, 3, 5);
    send(32'hFFC0A303, 100, 0, 1, 4'b0010, 32'hFFFFFFFC, 6);
    send(32'h0020A423, 64, 1, 1, 4'b0010, 8, 0);
    in_valid = 0;
    @(negedge clk);
    #1 chk("b2b_run", vrun, 4);
    cyc(3);
    chk("b2b_cnt", issue_count, c0 + 4);
    send(32'h0020B3B3, 1, 2, 1, 4'b1000, 2, 7);
    send(32'h00309093, 3, 0, 1, 4'b1001, 3, 1);
    in_valid = 0;
    cyc(3);
    c0 = model_cnt;
    send(32'h0000007F, 1, 1, 0, 0, 0, 0);
    send(32'h4020C233, 1, 1, 0, 0, 0, 0);
    send(32'h0020A063, 1, 1, 0, 0, 0, 0);
    send(32'h40309093, 1, 1, 0, 0, 0, 0);
    in_valid = 0;
    cyc(3);
    chk("ill_pulses", got_ill, exp_ill);
    chk("ill_clear", illegal, 0);
    chk("ill_cnt", issue_count, c0);
    out_ready = 0;
    send(32'h002081B3, 1, 2, 1, 4'b0010, 2, 3);
    in_valid = 0;
    c0 = got_ill;
    flush = 1; in_valid = 1; instr = 32'h002081B3;
    cyc(1);
    instr = 32'h0000007F;
    cyc(1);
    flush = 0; in_valid = 0;
    q.delete();
    chk("flush_valid", out_valid, 0);
    out_ready = 1;
    cyc(3);
    chk("flush_no_ill", got_ill, c0);
    chk("flush_cnt", issue_count, model_cnt);
    send(32'h002081B3, 4, 4, 1, 4'b0010, 4, 3);
    in_valid = 0;
    flush = 1;
    cyc(1);
    flush = 0;
    chk("flush_hand_valid", out_valid, 0);
    chk("flush_hand_cnt", issue_count, model_cnt);
    out_ready = 0;
    send(32'h002081B3, 8, 8, 1, 4'b0010, 8, 3);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_cnt", issue_count, 0);
    chk("arst_in1", in1, 0);
    q.delete();
    model_cnt = 0;
    @(negedge clk) rst_n = 1;
    out_ready = 1;
    cyc(1);
    send(32'h002081B3, 2, 3, 1, 4'b0010, 3, 3);
    in_valid = 0;
    cyc(3);
    chk("post_rst_cnt", issue_count, 1);
    chk("q_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
